// File: rtl/mac_stream.sv
// mac_stream: streaming 16-lane pixel x weight multiply-accumulate.
// Each accepted beat is reduced to one full-width partial sum (stage 1). That
// partial is added into a saturating or wrapping accumulator one edge later
// (stage 2). After BEATS beats the result is held until the consumer takes it.
module mac_stream #(
   parameter int unsigned LANES    = 16,
   parameter int unsigned DW       = 8,
   parameter int unsigned BEATS    = 49,
   parameter int unsigned ACCW     = 32,
   parameter int unsigned SIGNED_W = 1,
   parameter int unsigned SAT      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   pixels,
   input  logic [LANES*DW-1:0]   weights,
   output logic [ACCW-1:0]       sum,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  ovf
);

   localparam int unsigned PSW = 2*DW + 1 + $clog2(LANES);
   localparam int unsigned EW  = ((ACCW > PSW) ? ACCW : PSW) + 2;
   localparam int unsigned CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned MW  = 2*DW + 2;

   localparam logic signed [EW-1:0] SMAX = {{(EW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
   localparam logic signed [EW-1:0] SMIN = {{(EW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};
   localparam logic signed [EW-1:0] UMAX = {{(EW-ACCW){1'b0}}, {ACCW{1'b1}}};

   typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic signed [PSW-1:0]  part;
   logic signed [PSW-1:0]  psum;
   logic [ACCW-1:0]        acc;
   logic [ACCW-1:0]        acc_n;
   logic                   ovf_c;
   logic                   accept;
   logic signed [DW:0]     pe;
   logic signed [DW:0]     we;
   logic signed [MW-1:0]   prod;
   logic signed [EW-1:0]   acc_x;
   logic signed [EW-1:0]   add_x;
   logic                   hi;
   logic                   lo;

   assign in_ready = (state == ACCUM) && !rst;
   assign accept   = in_valid && in_ready;
   assign sum      = acc;

   // Stage-1 combinational: per-lane products summed at full width
   always_comb begin
      psum = '0;
      pe   = '0;
      we   = '0;
      prod = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         pe = $signed({1'b0, pixels[i*DW +: DW]});
         if (SIGNED_W != 0)
            we = $signed({weights[i*DW+DW-1], weights[i*DW +: DW]});
         else
            we = $signed({1'b0, weights[i*DW +: DW]});
         prod = MW'(pe) * MW'(we);
         psum = psum + PSW'(prod);
      end
   end

   // Stage-2 combinational: widened add with range detection and optional clamp
   always_comb begin
      if (SIGNED_W != 0)
         acc_x = EW'($signed(acc));
      else
         acc_x = $signed(EW'(acc));
      add_x = acc_x + EW'(part);
      if (SIGNED_W != 0) begin
         hi = add_x > SMAX;
         lo = add_x < SMIN;
      end else begin
         hi = add_x > UMAX;
         lo = 1'b0;
      end
      ovf_c = hi | lo;
      acc_n = add_x[ACCW-1:0];
      if (SAT != 0) begin
         if (hi) begin
            if (SIGNED_W != 0)
               acc_n = {1'b0, {(ACCW-1){1'b1}}};
            else
               acc_n = '1;
         end else if (lo) begin
            acc_n = {1'b1, {(ACCW-1){1'b0}}};
         end
      end
   end

   // Control FSM, stage-1 partial register, accumulator and result flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         cnt       <= '0;
         part      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         // a bubble loads zero so stage 2 can add unconditionally
         part <= accept ? psum : '0;
         case (state)
            ACCUM: begin
               acc <= acc_n;
               ovf <= ovf | ovf_c;
               if (accept) begin
                  if (cnt == CW'(BEATS-1)) begin
                     cnt   <= '0;
                     state <= FLUSH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FLUSH: begin
               acc       <= acc_n;
               ovf       <= ovf | ovf_c;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed bench driving five mac_stream configurations in
// lockstep from one stimulus stream, each checked against hand-computed sums.
//   u0: ACCW=32 unsigned weights, saturate
//   u1: ACCW=32 signed weights,   saturate
//   u2: ACCW=20 unsigned weights, saturate
//   u3: ACCW=20 unsigned weights, wrap
//   u4: ACCW=20 signed weights,   saturate
module tb_mac_stream;

   localparam int unsigned LANES = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned BEATS = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  out_ready;
   logic [LANES*DW-1:0]   pixels;
   logic [LANES*DW-1:0]   weights;
   logic [4:0]            in_ready;
   logic [4:0]            out_valid;
   logic [4:0]            ovf;
   logic [31:0]           s0, s1;
   logic [19:0]           s2, s3, s4;
   logic [31:0]           sum_a [5];

   int                    n_cmp = 0;
   int                    n_err = 0;
   logic [31:0]           es [5];
   logic [4:0]            eo;

   always #5 clk = ~clk;

   always_comb begin
      sum_a[0] = s0;
      sum_a[1] = s1;
      sum_a[2] = {12'h000, s2};
      sum_a[3] = {12'h000, s3};
      sum_a[4] = {12'h000, s4};
   end

   mac_stream #(.LANES(LANES), .DW(DW), .BEATS(BEATS), .ACCW(32), .SIGNED_W(0), .SAT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .pixels(pixels), .weights(weights), .sum(s0), .out_valid(out_valid[0]),
      .out_ready(out_ready), .ovf(ovf[0]));

   mac_stream #(.LANES(LANES), .DW(DW), .BEATS(BEATS), .ACCW(32), .SIGNED_W(1), .SAT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .pixels(pixels), .weights(weights), .sum(s1), .out_valid(out_valid[1]),
      .out_ready(out_ready), .ovf(ovf[1]));

   mac_stream #(.LANES(LANES), .DW(DW), .BEATS(BEATS), .ACCW(20), .SIGNED_W(0), .SAT(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .pixels(pixels), .weights(weights), .sum(s2), .out_valid(out_valid[2]),
      .out_ready(out_ready), .ovf(ovf[2]));

   mac_stream #(.LANES(LANES), .DW(DW), .BEATS(BEATS), .ACCW(20), .SIGNED_W(0), .SAT(0)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
      .pixels(pixels), .weights(weights), .sum(s3), .out_valid(out_valid[3]),
      .out_ready(out_ready), .ovf(ovf[3]));

   mac_stream #(.LANES(LANES), .DW(DW), .BEATS(BEATS), .ACCW(20), .SIGNED_W(1), .SAT(1)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[4]),
      .pixels(pixels), .weights(weights), .sum(s4), .out_valid(out_valid[4]),
      .out_ready(out_ready), .ovf(ovf[4]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d, input logic [31:0] e, input logic [4:0] o);
      es[0] = a; es[1] = b; es[2] = c; es[3] = d; es[4] = e;
      eo = o;
   endtask

   // starts and ends just after a falling edge
   task automatic send_beat(input logic [7:0] p, input logic [7:0] w, input int unsigned gap);
      int unsigned n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      pixels   = {LANES{p}};
      weights  = {LANES{w}};
      in_valid = 1'b1;
      n = 0;
      while (!in_ready[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[0]) check("beat_wait", {31'h0, in_ready[0]}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int unsigned hold, input logic busy);
      int unsigned n;
      n = 0;
      while (!out_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         check($sformatf("%s_sum[%0d]", tag, k), sum_a[k], es[k]);
         check($sformatf("%s_ovf[%0d]", tag, k), {31'h0, ovf[k]}, {31'h0, eo[k]});
         check($sformatf("%s_vld[%0d]", tag, k), {31'h0, out_valid[k]}, 32'h1);
      end
      check($sformatf("%s_rdy_hold", tag), {27'h0, in_ready}, 32'h0);
      if (busy) begin
         pixels   = {LANES{8'hFF}};
         weights  = {LANES{8'hFF}};
         in_valid = 1'b1;
      end
      for (int unsigned c = 0; c < hold; c++) begin
         @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_stable_sum[%0d]", tag, k), sum_a[k], es[k]);
            check($sformatf("%s_stable_ovf[%0d]", tag, k), {31'h0, ovf[k]}, {31'h0, eo[k]});
         end
         check($sformatf("%s_stable_vld", tag), {27'h0, out_valid}, 32'h1F);
         check($sformatf("%s_stable_rdy", tag), {27'h0, in_ready}, 32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("%s_vld_clr", tag), {27'h0, out_valid}, 32'h0);
      check($sformatf("%s_ovf_clr", tag), {27'h0, ovf}, 32'h0);
      check($sformatf("%s_rdy_back", tag), {27'h0, in_ready}, 32'h1F);
      for (int k = 0; k < 5; k++)
         check($sformatf("%s_acc_clr[%0d]", tag, k), sum_a[k], 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pixels    = '0;
      weights   = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_rdy", {27'h0, in_ready}, 32'h0);
      check("rst_vld", {27'h0, out_valid}, 32'h0);
      check("rst_ovf", {27'h0, ovf}, 32'h0);
      for (int k = 0; k < 5; k++)
         check($sformatf("rst_sum[%0d]", k), sum_a[k], 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_rdy", {27'h0, in_ready}, 32'h1F);

      // 0x01 x 0x01, back-to-back, with latency check
      for (int b = 0; b < 4; b++) send_beat(8'h01, 8'h01, 0);
      check("lat_flush_vld", {27'h0, out_valid}, 32'h0);
      check("lat_flush_rdy", {27'h0, in_ready}, 32'h0);
      @(negedge clk);
      check("lat_hold_vld", {27'h0, out_valid}, 32'h1F);
      set_exp(32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 5'b00000);
      expect_result("p1", 0, 1'b0);

      // 0xFF x 0x80; out_ready held high during ACCUM must be ignored
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) send_beat(8'hFF, 8'h80, 0);
      out_ready = 1'b0;
      set_exp(32'h001FE000, 32'hFFE02000, 32'h000FFFFF, 32'h000FE000, 32'h00080000, 5'b11100);
      expect_result("p2", 0, 1'b0);

      // 0xFF x 0xFF
      for (int b = 0; b < 4; b++) send_beat(8'hFF, 8'hFF, 0);
      set_exp(32'h003F8040, 32'hFFFFC040, 32'h000FFFFF, 32'h000F8040, 32'h000FC040, 5'b01100);
      expect_result("p3", 0, 1'b0);

      // clamp persistence: three positive beats then one negative beat
      for (int b = 0; b < 3; b++) send_beat(8'hFF, 8'h7F, 0);
      send_beat(8'hFF, 8'h80, 0);
      set_exp(32'h001FB030, 32'h000FC030, 32'h000FFFFF, 32'h000FB030, 32'h000007FF, 5'b11100);
      expect_result("p4", 0, 1'b0);

      // backpressure: 5 cycles in HOLD with in_valid high, then next packet
      for (int b = 0; b < 4; b++) send_beat(8'h01, 8'h01, 0);
      set_exp(32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 5'b00000);
      expect_result("bp", 5, 1'b1);
      for (int b = 0; b < 4; b++) send_beat(8'h01, 8'h01, 0);
      expect_result("bp_next", 0, 1'b0);

      // reset after two beats discards the packet
      send_beat(8'h01, 8'h01, 0);
      send_beat(8'h01, 8'h01, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_rdy", {27'h0, in_ready}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_vld", {27'h0, out_valid}, 32'h0);
      check("mid_rst_ovf", {27'h0, ovf}, 32'h0);
      for (int k = 0; k < 5; k++)
         check($sformatf("mid_rst_sum[%0d]", k), sum_a[k], 32'h0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post_rst_vld", {27'h0, out_valid}, 32'h0);
      for (int b = 0; b < 4; b++) send_beat(8'h02, 8'h03, 0);
      set_exp(32'h180, 32'h180, 32'h180, 32'h180, 32'h180, 5'b00000);
      expect_result("after_rst", 0, 1'b0);

      // random in_valid gaps and out_ready delays; beat k carries pixel k+1
      set_exp(32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 5'b00000);
      for (int p = 0; p < 100; p++) begin
         for (int b = 0; b < 4; b++)
            send_beat(8'(b + 1), 8'h01, $urandom_range(0, 3));
         expect_result($sformatf("gap%0d", p), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
